rocket_mover: RTL and testbench
===============================

Name: rocket_mover

Overview:
- Per-rocket motion engine, one instance per bit of the isActivePlayers / isActiveAliens buses.
- Sits directly downstream of the rockets controller and consumes its isActive bit and initialSpeed / initialX / initialY launch values.
- Integrates vertical position once per frame in Q.6 fixed point (pixels/64).
- Drives the rocket's top-left to the drawing/collision logic and raises reachedBorder back to the controller.

Parameters:
- SCREEN_H, 480, visible screen height in pixels.
- ROCKET_H, 16, rocket sprite height in pixels.
- FRAC_BITS, 6, fractional bits of position/speed (speed unit = pixels/64 per frame).
- ACCEL, 4, speed magnitude added per frame when ROCKET_ACCEL_EN is defined.
- MAX_SPEED, 512, saturation magnitude when ROCKET_ACCEL_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- isActive  in  1  active flag for this rocket from the rockets controller
- startOfFrame  in  1  one-clock pulse per frame (30 Hz)
- initialSpeed  in  11 signed  launch speed, pixels/64 per frame; negative = upward
- initialX  in  11 signed  launch top-left X
- initialY  in  11 signed  launch top-left Y
- topLeftX  out  11 signed  current top-left X
- topLeftY  out  11 signed  current top-left Y (integer part of the fixed-point Y)
- rocketVisible  out  1  rocket is in flight and drawable
- reachedBorder  out  1  rocket left the screen vertically; level signal

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, topLeftX=0, topLeftY=0, rocketVisible=0, reachedBorder=0.
  - Internal yFix=0, speed=0, isActive_d=0.
- Internal registers:
  - yFix: signed, 11+FRAC_BITS = 17 bits.
  - speed: signed, 11 bits.
  - isActive_d: registered copy of isActive, used for rise detection.
- Launch (rise = isActive & ~isActive_d, any state):
  - Load yFix = initialY << FRAC_BITS, topLeftX = initialX, speed = initialSpeed.
  - Go to FLYING; rocketVisible=1 from the next cycle.
  - The launch values are sampled on the rise cycle itself; the controller updates them in the same clock as isActive, so they are valid together.
- State machine:
  - IDLE: rocketVisible=0, reachedBorder=0. Stays until a rise.
  - FLYING:
    - On startOfFrame: yFix <= yFix + sign-extended speed.
    - topLeftY = yFix >>> FRAC_BITS (arithmetic shift, truncates toward negative infinity).
    - The border check uses the updated topLeftY. If topLeftY < 0 or topLeftY > SCREEN_H-ROCKET_H: go to EXPIRED. reachedBorder rises one clock after the frame that crossed.
  - EXPIRED: rocketVisible=0, reachedBorder=1, position frozen. Held until isActive falls.
- Falling isActive (any state) → IDLE next clock; reachedBorder and rocketVisible cleared. This covers a hit, a collision, or the controller's border response.
- Simultaneous events:
  - A rise coinciding with startOfFrame: the launch wins; no motion applied that frame.
  - isActive low coinciding with startOfFrame: go to IDLE; no motion.
  - A rise while in EXPIRED or FLYING (1-cycle drop missed is impossible; a rise needs isActive_d=0): normal launch.
- Latency:
  - Position update visible 1 clock after startOfFrame.
  - reachedBorder visible 1 clock after the crossing update.
- Arithmetic: the yFix addition cannot overflow in normal operation (|speed| ≤ 1023, yFix range ±65535). No saturation on position.

Optional Feature:
- ROCKET_ACCEL_EN defined:
  - Each startOfFrame in FLYING, after the position update, |speed| increases by ACCEL, saturating at MAX_SPEED. Sign is kept.
  - A speed of 0 is never accelerated.
- Not defined: speed is constant for the whole flight.

Test Plan:
- Reset with isActive=1 held → all outputs 0, state IDLE. Deassert reset, then drop and raise isActive → launch occurs.
- Launch X=200, Y=400, speed=-128; 10 startOfFrame pulses → topLeftY=380, topLeftX=200, rocketVisible=1, reachedBorder=0.
- Launch Y=100, speed=32; 3 frames → topLeftY=101 (yFix=6496); 4th frame → 102.
- Launch Y=2, speed=-128 → frame 1 Y=0 still FLYING; frame 2 Y=-2, reachedBorder=1 next clock and rocketVisible=0. Drop isActive → both 0 next clock.
- Launch Y=460, speed=256 → frame 1 Y=464 (limit); frame 2 Y=468 → reachedBorder=1. Launch with startOfFrame in the same cycle → Y stays 460 that frame.
- With ROCKET_ACCEL_EN: speed=-128, ACCEL=4 → after 3 frames speed=-140, yFix = initial - 128 - 132 - 136. Speed starting at 510 → saturates at 512.

Source files
------------

// File: rtl/rocket_mover_if.sv
// Launch/position bundle between the rockets controller (master) and one
// rocket_mover instance (slave).
interface rocket_mover_if;
  logic               isActive;
  logic               startOfFrame;
  logic signed [10:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               rocketVisible;
  logic               reachedBorder;

  modport master (
    output isActive, startOfFrame, initialSpeed, initialX, initialY,
    input  topLeftX, topLeftY, rocketVisible, reachedBorder
  );

  modport slave (
    input  isActive, startOfFrame, initialSpeed, initialX, initialY,
    output topLeftX, topLeftY, rocketVisible, reachedBorder
  );
endinterface

// File: rtl/rocket_mover.sv
// Per-rocket vertical motion engine: fixed-point Y integration once per frame,
// border detection back to the controller. ROCKET_ACCEL_EN adds per-frame speed-up.
//
// state   | meaning
// IDLE    | rocket not launched, nothing drawn
// FLYING  | moving each frame, drawable
// EXPIRED | left the screen vertically, frozen until isActive drops
module rocket_mover #(
  parameter int SCREEN_H  = 480,
  parameter int ROCKET_H  = 16,
  parameter int FRAC_BITS = 6
`ifdef ROCKET_ACCEL_EN
  ,
  parameter int ACCEL     = 4,
  parameter int MAX_SPEED = 512
`endif
) (
  input logic          clk,
  input logic          reset,
  rocket_mover_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLYING, EXPIRED} state_t;

  localparam logic signed [10:0] Y_LIMIT = 11'(SCREEN_H - ROCKET_H);

  state_t                       state;
  logic signed [10+FRAC_BITS:0] y_fix;
  logic signed [10:0]           speed;
  logic                         is_active_d;
  logic                         check_pending;
  logic signed [10:0]           pos_x;
  logic                         visible;
  logic                         border;

  logic                         rise;
  logic signed [10:0]           y_int;
  logic                         out_of_range;
  logic        [10+FRAC_BITS:0] speed_ext;
  logic        [10:0]           speed_next;

  assign rise         = bus.isActive & ~is_active_d;
  assign y_int        = y_fix[FRAC_BITS +: 11];
  assign out_of_range = y_int[10] | (y_int > Y_LIMIT);
  assign speed_ext    = {{FRAC_BITS{speed[10]}}, speed};

`ifdef ROCKET_ACCEL_EN
  localparam logic signed [11:0] ACC_W = 12'(ACCEL);
  localparam logic signed [11:0] MAX_W = 12'(MAX_SPEED);

  logic signed [11:0] speed_wide;
  logic signed [11:0] speed_up;
  logic signed [11:0] speed_dn;

  // Magnitude grows away from zero; a stationary rocket stays stationary.
  always_comb begin
    speed_wide = {speed[10], speed};
    speed_up   = speed_wide + ACC_W;
    speed_dn   = speed_wide - ACC_W;
    speed_next = speed;
    if (speed_wide > 12'sd0)
      speed_next = (speed_up > MAX_W) ? MAX_W[10:0] : speed_up[10:0];
    else if (speed_wide < 12'sd0)
      speed_next = (speed_dn < -MAX_W) ? 11'(-MAX_W) : speed_dn[10:0];
  end
`else
  assign speed_next = speed;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      y_fix         <= '0;
      speed         <= '0;
      is_active_d   <= 1'b0;
      check_pending <= 1'b0;
      pos_x         <= '0;
      visible       <= 1'b0;
      border        <= 1'b0;
    end else begin
      is_active_d <= bus.isActive;
      if (rise) begin
        state         <= FLYING;
        y_fix         <= {bus.initialY, FRAC_BITS'(0)};
        pos_x         <= bus.initialX;
        speed         <= bus.initialSpeed;
        check_pending <= 1'b0;
        visible       <= 1'b1;
        border        <= 1'b0;
      end else if (!bus.isActive) begin
        state         <= IDLE;
        check_pending <= 1'b0;
        visible       <= 1'b0;
        border        <= 1'b0;
      end else begin
        case (state)
          FLYING: begin
            // Border is judged on the freshly updated position one clock later.
            if (check_pending && out_of_range) begin
              state         <= EXPIRED;
              check_pending <= 1'b0;
              visible       <= 1'b0;
              border        <= 1'b1;
            end else if (bus.startOfFrame) begin
              y_fix         <= y_fix + speed_ext;
              speed         <= speed_next;
              check_pending <= 1'b1;
            end else begin
              check_pending <= 1'b0;
            end
          end
          IDLE, EXPIRED: check_pending <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.topLeftX      = pos_x;
  assign bus.topLeftY      = y_int;
  assign bus.rocketVisible = visible;
  assign bus.reachedBorder = border;

endmodule

// File: tb/tb_rocket_mover.sv
// Directed bench for rocket_mover: launch, per-frame motion, both borders,
// simultaneous launch/frame and drop/frame cases.
module tb_rocket_mover;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rocket_mover_if bus ();

  rocket_mover dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int x, input int y, input int s);
    bus.initialX     = 11'(x);
    bus.initialY     = 11'(y);
    bus.initialSpeed = 11'(s);
    bus.isActive     = 1'b1;
    tick();
  endtask

  task automatic drop();
    bus.isActive = 1'b0;
    tick();
  endtask

  // One frame pulse plus a settling clock for the border check.
  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset            = 1'b1;
    bus.isActive     = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.initialX     = 11'sd77;
    bus.initialY     = 11'sd99;
    bus.initialSpeed = 11'sd5;
    repeat (3) tick();
    check_val("rst_x", int'(bus.topLeftX), 0);
    check_val("rst_y", int'(bus.topLeftY), 0);
    check_val("rst_vis", int'(bus.rocketVisible), 0);
    check_val("rst_border", int'(bus.reachedBorder), 0);

    reset        = 1'b0;
    bus.isActive = 1'b0;
    tick();
    check_val("idle_vis", int'(bus.rocketVisible), 0);

    // Upward flight, 10 frames
    launch(200, 400, -128);
    check_val("launch_x", int'(bus.topLeftX), 200);
    check_val("launch_y", int'(bus.topLeftY), 400);
    check_val("launch_vis", int'(bus.rocketVisible), 1);
    repeat (10) frame();
`ifdef ROCKET_ACCEL_EN
    check_val("up10_y", int'(bus.topLeftY), 377);
`else
    check_val("up10_y", int'(bus.topLeftY), 380);
`endif
    check_val("up10_x", int'(bus.topLeftX), 200);
    check_val("up10_vis", int'(bus.rocketVisible), 1);
    check_val("up10_border", int'(bus.reachedBorder), 0);
    drop();
    check_val("drop_vis", int'(bus.rocketVisible), 0);

    // Sub-pixel accumulation
    launch(10, 100, 32);
    repeat (3) frame();
    check_val("frac3_y", int'(bus.topLeftY), 101);
    frame();
    check_val("frac4_y", int'(bus.topLeftY), 102);
    drop();

    // Top border
    launch(50, 2, -128);
    frame();
    check_val("top1_y", int'(bus.topLeftY), 0);
    check_val("top1_border", int'(bus.reachedBorder), 0);
    check_val("top1_vis", int'(bus.rocketVisible), 1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
`ifdef ROCKET_ACCEL_EN
    check_val("top2_y", int'(bus.topLeftY), -3);
`else
    check_val("top2_y", int'(bus.topLeftY), -2);
`endif
    check_val("top2_border_early", int'(bus.reachedBorder), 0);
    tick();
    check_val("top2_border", int'(bus.reachedBorder), 1);
    check_val("top2_vis", int'(bus.rocketVisible), 0);
    frame();
`ifdef ROCKET_ACCEL_EN
    check_val("expired_frozen_y", int'(bus.topLeftY), -3);
`else
    check_val("expired_frozen_y", int'(bus.topLeftY), -2);
`endif
    check_val("expired_border_held", int'(bus.reachedBorder), 1);
    drop();
    check_val("top_drop_border", int'(bus.reachedBorder), 0);
    check_val("top_drop_vis", int'(bus.rocketVisible), 0);

    // Bottom border: 464 is still on screen, 468 is not
    launch(300, 460, 256);
    frame();
    check_val("bot1_y", int'(bus.topLeftY), 464);
    check_val("bot1_border", int'(bus.reachedBorder), 0);
    frame();
    check_val("bot2_y", int'(bus.topLeftY), 468);
    check_val("bot2_border", int'(bus.reachedBorder), 1);
    drop();

    // Launch coinciding with a frame pulse: no motion that frame
    bus.startOfFrame = 1'b1;
    launch(120, 460, 256);
    bus.startOfFrame = 1'b0;
    check_val("sof_launch_y", int'(bus.topLeftY), 460);
    check_val("sof_launch_x", int'(bus.topLeftX), 120);
    tick();
    check_val("sof_launch_y_hold", int'(bus.topLeftY), 460);
    check_val("sof_launch_vis", int'(bus.rocketVisible), 1);

    // Drop coinciding with a frame pulse: idle, no motion
    bus.startOfFrame = 1'b1;
    drop();
    bus.startOfFrame = 1'b0;
    check_val("sof_drop_vis", int'(bus.rocketVisible), 0);
    check_val("sof_drop_y", int'(bus.topLeftY), 460);

    // Zero speed never moves
    launch(-5, 240, 0);
    check_val("neg_x", int'(bus.topLeftX), -5);
    repeat (3) frame();
    check_val("zero_speed_y", int'(bus.topLeftY), 240);
    drop();

`ifdef ROCKET_ACCEL_EN
    // -128,-132,-136 applied: 25600-396 = 25204 -> 393
    launch(0, 400, -128);
    repeat (3) frame();
    check_val("accel_y", int'(bus.topLeftY), 393);
    drop();
    // 510 then clamped 512,512: 0+510+512+512 = 1534 -> 23; next 2046 -> 31
    launch(0, 0, 510);
    repeat (3) frame();
    check_val("accel_sat_y3", int'(bus.topLeftY), 23);
    frame();
    check_val("accel_sat_y4", int'(bus.topLeftY), 31);
    drop();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
